wb_write_buffer: RTL and testbench
==================================

# wb_write_buffer

Writeback-side write buffer for the 8x16b register file. Accepts register write requests from the pipeline over a valid/ready handshake, queues up to DEPTH of them in order, and drains one per cycle onto the register file write port (`writeRegSel`/`writeData`/`writeEn`), holding while the port is stalled. Sits between the writeback stage and the bypassing register file. It also exposes pending-write lookup so decode can forward values not yet written.

## Interface
- N, 16, data width
- DEPTH, 4, queue entries (power of two, 2..8)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  write request present
- in_reg  in  3  destination register of request
- in_data  in  N  write data of request
- in_ready  out  1  buffer can accept this cycle
- drain_stall  in  1  register file port unavailable this cycle
- writeRegSel  out  3  register file write select (head entry)
- writeData  out  N  register file write data (head entry)
- writeEn  out  1  register file write enable
- lookup1Sel, lookup2Sel  in  3 each  registers being read by decode
- lookup1Hit, lookup2Hit  out  1 each  a pending entry targets that register
- lookup1Data, lookup2Data  out  N each  data of youngest matching pending entry
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular queue: storage array, head pointer, tail pointer, occupancy counter; pointers wrap modulo DEPTH.
- Push: `in_valid & in_ready` at a rising edge writes {in_reg, in_data} at tail, tail advances.
- `in_ready = (count != DEPTH)`; combinational from registered count only, never from `in_valid` or `drain_stall`.
- Pop: `writeEn = (count != 0) & ~drain_stall`; when 1, `writeRegSel`/`writeData` show head entry, head advances at the edge.
- `writeRegSel`/`writeData` show head entry whenever count != 0; 0 when empty.
- Simultaneous push and pop: count unchanged, both pointers advance. With count == DEPTH, push is refused (in_ready = 0) even if pop occurs that cycle.
- Lookup: combinational search of occupied entries only; the incoming in_* request is not searched. Multiple matches: youngest (closest to tail) wins. No match: Hit = 0, Data = 0.
- Head entry being written this cycle still reports a hit (the register file bypass covers the same cycle; both values agree).
- Writes to any register, including r0, are queued and drained unchanged.
- Order preserved: entries reach the write port in acceptance order, one per cycle maximum.

## Timing
- Reset (rst_n low, asynchronous): count = 0, head = tail = 0, writeEn = 0, writeRegSel = 0, writeData = 0, in_ready = 1, lookup Hits = 0. Queued entries discarded; storage contents need not be cleared.
- Reset asserted mid-operation discards all pending writes immediately; no write is emitted after the assertion.
- Latency: request accepted at edge k appears on the write port in cycle k+1 at the earliest (no fall-through). Visible to lookup from cycle k+1.
- Full throughput: continuous push with no stall sustains one write per cycle at count = 1.
- drain_stall held: writeEn = 0, head held, pushes accepted until count = DEPTH.

## Configuration
- `WB_LOOKUP_EN` defined: lookup logic present as described.
- Not defined: lookup logic omitted; lookup1Hit/lookup2Hit and lookup1Data/lookup2Data tied to 0, lookupSel inputs ignored. Queue behaviour unchanged.

## Test plan
- Reset then single push {r3, 0x1234} with no stall -> next cycle writeEn = 1, writeRegSel = 3, writeData = 0x1234; following cycle writeEn = 0, count = 0.
- drain_stall = 1, push r1..r4 with 0xA001..0xA004 -> count = 4, in_ready = 0; fifth push held off; release stall -> four writes in order r1..r4 on consecutive cycles, in_ready = 1 after first drain.
- Stall, push {r2, 0x1111} then {r2, 0x2222}; lookup1Sel = 2 -> lookup1Hit = 1, lookup1Data = 0x2222; lookup2Sel = 5 -> lookup2Hit = 0, lookup2Data = 0.
- Continuous push every cycle, no stall, 10 requests -> 10 writes on 10 consecutive cycles with one cycle latency, count never exceeds 1, pointers wrap correctly.
- Fill to 3 entries under stall, deassert rst_n asynchronously mid-cycle -> count = 0, writeEn = 0, in_ready = 1 immediately; after release no stale write appears.
- Build without `WB_LOOKUP_EN`, repeat lookup scenario -> both Hits and Datas 0; write stream identical to lookup-enabled build.

Source files
------------

// File: rtl/wb_write_buffer.sv
// rtl/wb_write_buffer.sv - In-order register write buffer between writeback and the register file
//
// Queues register write requests from the writeback stage and drains them in
// acceptance order, at most one per cycle, onto the register file write port.
// A drain is held off while the port is stalled. With `WB_LOOKUP_EN defined,
// two combinational lookup ports report the youngest pending write to a
// register so decode can forward data that has not reached the register file.
// Without WB_LOOKUP_EN the lookup outputs are tied to 0 and the selects are ignored.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          request handshake; in_reg/in_data carry the write
//   drain_stall                register file write port unavailable this cycle
//   writeRegSel/writeData      head entry (0 when empty)
//   writeEn                    head entry is written this cycle
//   lookup1Sel/lookup2Sel      registers being read by decode
//   lookup1Hit/lookup2Hit      a pending entry targets that register
//   lookup1Data/lookup2Data    data of the youngest matching pending entry
//   count                      occupied entries
module wb_write_buffer #(
  parameter int N     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [2:0]               in_reg,
  input  logic [N-1:0]             in_data,
  output logic                     in_ready,
  input  logic                     drain_stall,
  output logic [2:0]               writeRegSel,
  output logic [N-1:0]             writeData,
  output logic                     writeEn,
  input  logic [2:0]               lookup1Sel,
  input  logic [2:0]               lookup2Sel,
  output logic                     lookup1Hit,
  output logic                     lookup2Hit,
  output logic [N-1:0]             lookup1Data,
  output logic [N-1:0]             lookup2Data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [2:0]    regMem  [DEPTH];
  logic [N-1:0]  dataMem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          empty;
  logic          full;
  logic          push;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  // Depends only on registered count, so a full buffer refuses a push even
  // in a cycle where it also drains.
  assign in_ready = ~full;
  assign push     = in_valid & in_ready;

  assign writeEn     = ~empty & ~drain_stall;
  assign writeRegSel = empty ? 3'd0 : regMem[head];
  assign writeData   = empty ? '0 : dataMem[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (writeEn) head <= head + 1'b1;
      case ({push, writeEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      regMem[tail]  <= in_reg;
      dataMem[tail] <= in_data;
    end
  end

`ifdef WB_LOOKUP_EN
  // Walk live entries oldest to youngest so the youngest match overwrites
  // older ones. The head entry still hits while it is being written; the
  // register file bypass sees the same value that cycle.
  always_comb begin
    lookup1Hit  = 1'b0;
    lookup2Hit  = 1'b0;
    lookup1Data = '0;
    lookup2Data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if (regMem[head + PW'(i)] == lookup1Sel) begin
          lookup1Hit  = 1'b1;
          lookup1Data = dataMem[head + PW'(i)];
        end
        if (regMem[head + PW'(i)] == lookup2Sel) begin
          lookup2Hit  = 1'b1;
          lookup2Data = dataMem[head + PW'(i)];
        end
      end
    end
  end
`else
  logic unusedLookupSel;
  assign unusedLookupSel = ^{lookup1Sel, lookup2Sel};
  assign lookup1Hit  = 1'b0;
  assign lookup2Hit  = 1'b0;
  assign lookup1Data = '0;
  assign lookup2Data = '0;
`endif

endmodule

// File: tb/tb_wb_write_buffer.sv
// tb/tb_wb_write_buffer.sv - Directed self-checking bench for wb_write_buffer
module tb_wb_write_buffer;

`ifdef WB_LOOKUP_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_reg;
  logic [15:0] in_data;
  logic        in_ready;
  logic        drain_stall;
  logic [2:0]  writeRegSel;
  logic [15:0] writeData;
  logic        writeEn;
  logic [2:0]  lookup1Sel;
  logic [2:0]  lookup2Sel;
  logic        lookup1Hit;
  logic        lookup2Hit;
  logic [15:0] lookup1Data;
  logic [15:0] lookup2Data;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;

  wb_write_buffer #(.N(16), .DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_reg(in_reg),
    .in_data(in_data),
    .in_ready(in_ready),
    .drain_stall(drain_stall),
    .writeRegSel(writeRegSel),
    .writeData(writeData),
    .writeEn(writeEn),
    .lookup1Sel(lookup1Sel),
    .lookup2Sel(lookup2Sel),
    .lookup1Hit(lookup1Hit),
    .lookup2Hit(lookup2Hit),
    .lookup1Data(lookup1Data),
    .lookup2Data(lookup2Data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_reg = '0;
    in_data = '0;
    drain_stall = 1'b0;
    lookup1Sel = '0;
    lookup2Sel = '0;

    // Reset state
    tick();
    tick();
    settle();
    chk("rst_count", count, 0);
    chk("rst_we", writeEn, 0);
    chk("rst_sel", writeRegSel, 0);
    chk("rst_data", writeData, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_hit1", lookup1Hit, 0);
    chk("rst_hit2", lookup2Hit, 0);
    rst_n = 1'b1;
    tick();

    // Single push, one cycle latency, no fall-through
    in_valid = 1'b1; in_reg = 3'd3; in_data = 16'h1234; lookup1Sel = 3'd3;
    settle();
    chk("single_nofall_we", writeEn, 0);
    chk("single_incoming_not_searched", lookup1Hit, 0);
    tick();
    in_valid = 1'b0;
    settle();
    chk("single_we", writeEn, 1);
    chk("single_sel", writeRegSel, 3);
    chk("single_data", writeData, 16'h1234);
    chk("single_count", count, 1);
    chk("single_hit1", lookup1Hit, LK);
    chk("single_data1", lookup1Data, LK ? 16'h1234 : 16'h0);
    tick();
    settle();
    chk("single_after_we", writeEn, 0);
    chk("single_after_count", count, 0);
    chk("single_after_sel", writeRegSel, 0);

    // Fill under stall
    drain_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_reg = 3'(k + 1); in_data = 16'(16'hA001 + k);
      tick();
    end
    in_valid = 1'b0;
    settle();
    chk("full_count", count, 4);
    chk("full_ready", in_ready, 0);
    chk("full_we", writeEn, 0);
    chk("full_head_sel", writeRegSel, 1);
    chk("full_head_data", writeData, 16'hA001);
    in_valid = 1'b1; in_reg = 3'd5; in_data = 16'hB005;
    tick();
    settle();
    chk("full_fifth_held", count, 4);
    // Release stall while still full: pop happens, push refused
    drain_stall = 1'b0;
    settle();
    chk("fullpop_ready", in_ready, 0);
    chk("fullpop_we", writeEn, 1);
    chk("fullpop_sel", writeRegSel, 1);
    chk("fullpop_data", writeData, 16'hA001);
    tick();
    in_valid = 1'b0;
    settle();
    chk("fullpop_count", count, 3);
    chk("fullpop_ready_after", in_ready, 1);
    for (int k = 2; k <= 4; k++) begin
      chk("drain_we", writeEn, 1);
      chk("drain_sel", writeRegSel, k);
      chk("drain_data", writeData, 16'(16'hA000 + k));
      tick();
      settle();
    end
    chk("drain_empty_count", count, 0);
    chk("drain_empty_we", writeEn, 0);

    // Lookup: youngest match wins, incoming and dead entries not searched
    drain_stall = 1'b1;
    in_valid = 1'b1; in_reg = 3'd2; in_data = 16'h1111;
    tick();
    in_data = 16'h2222;
    tick();
    in_reg = 3'd5; in_data = 16'h5555;
    lookup1Sel = 3'd2; lookup2Sel = 3'd5;
    settle();
    chk("lk_count", count, 2);
    chk("lk_hit1", lookup1Hit, LK);
    chk("lk_data1", lookup1Data, LK ? 16'h2222 : 16'h0);
    chk("lk_hit2_incoming", lookup2Hit, 0);
    chk("lk_data2_incoming", lookup2Data, 0);
    in_valid = 1'b0;
    lookup2Sel = 3'd3;
    settle();
    chk("lk_hit2_dead", lookup2Hit, 0);
    chk("lk_data2_dead", lookup2Data, 0);
    drain_stall = 1'b0;
    settle();
    chk("lk_drain1_sel", writeRegSel, 2);
    chk("lk_drain1_data", writeData, 16'h1111);
    chk("lk_drain1_hit1", lookup1Hit, LK);
    chk("lk_drain1_data1", lookup1Data, LK ? 16'h2222 : 16'h0);
    tick();
    settle();
    chk("lk_drain2_data", writeData, 16'h2222);
    chk("lk_drain2_data1", lookup1Data, LK ? 16'h2222 : 16'h0);
    tick();
    settle();
    chk("lk_done_count", count, 0);
    chk("lk_done_hit1", lookup1Hit, 0);

    // Continuous push, full throughput, pointer wrap
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_reg = 3'(i); in_data = 16'(16'hC000 + i);
      settle();
      chk("stream_count", count, (i == 0) ? 0 : 1);
      chk("stream_ready", in_ready, 1);
      chk("stream_we", writeEn, (i == 0) ? 0 : 1);
      chk("stream_sel", writeRegSel, (i == 0) ? 0 : ((i - 1) % 8));
      chk("stream_data", writeData, (i == 0) ? 0 : (16'hC000 + i - 1));
      tick();
    end
    in_valid = 1'b0;
    settle();
    chk("stream_last_we", writeEn, 1);
    chk("stream_last_sel", writeRegSel, 1);
    chk("stream_last_data", writeData, 16'hC009);
    tick();
    settle();
    chk("stream_end_count", count, 0);
    chk("stream_end_we", writeEn, 0);

    // Asynchronous reset mid-cycle with entries pending
    drain_stall = 1'b1;
    in_valid = 1'b1; in_reg = 3'd7; in_data = 16'hD007;
    tick();
    in_reg = 3'd0; in_data = 16'hD000;
    tick();
    in_reg = 3'd4; in_data = 16'hD004;
    tick();
    in_valid = 1'b0;
    lookup1Sel = 3'd7;
    settle();
    chk("arst_pre_count", count, 3);
    chk("arst_pre_hit1", lookup1Hit, LK);
    #1;
    rst_n = 1'b0;
    drain_stall = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_we", writeEn, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_sel", writeRegSel, 0);
    chk("arst_data", writeData, 0);
    chk("arst_hit1", lookup1Hit, 0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("arst_rel_we", writeEn, 0);
    tick();
    settle();
    chk("arst_rel2_we", writeEn, 0);
    chk("arst_rel2_count", count, 0);
    in_valid = 1'b1; in_reg = 3'd6; in_data = 16'hE006;
    tick();
    in_valid = 1'b0;
    settle();
    chk("arst_resume_we", writeEn, 1);
    chk("arst_resume_sel", writeRegSel, 6);
    chk("arst_resume_data", writeData, 16'hE006);
    tick();
    settle();
    chk("arst_resume_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
